// File: rtl/reg_xfer_arbiter.sv
// Round-robin sequencer for register-to-register moves over the shared bus.
// Each granted move runs DRIVE -> WRITE -> DONE with all strobes registered.
module reg_xfer_arbiter #(
    parameter int NREQ = 4,
    parameter int NREG = 16,
    parameter int SELW = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*SELW-1:0] src_sel,
    input  logic [NREQ*SELW-1:0] dst_sel,
    input  logic [NREQ-1:0]      ba_mode,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [NREG-1:0]      rout,
    output logic [NREG-1:0]      rin,
    output logic                 baout,
    output logic                 busy
);
    localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [GW-1:0]   rr_q, rr_d;
    logic [GW-1:0]   g_q, g_d;
    logic [SELW-1:0] src_q, src_d;
    logic [SELW-1:0] dst_q, dst_d;
    logic            ba_q, ba_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic [NREG-1:0] rout_q, rout_d;
    logic [NREG-1:0] rin_q, rin_d;
    logic            baout_q, baout_d;
    logic            busy_q, busy_d;

    logic [GW-1:0]   pick;
    logic            found;
    logic [SELW-1:0] pick_src;
    logic [SELW-1:0] pick_dst;

    // Out-of-range indices decode to all zeros, so no register is strobed.
    function automatic logic [NREG-1:0] dec(input logic [SELW-1:0] s);
        logic [NREG-1:0] v;
        v = '0;
        for (int r = 0; r < NREG; r++) begin
            if (s == SELW'(r)) v[r] = 1'b1;
        end
        return v;
    endfunction

    // Search upward from the slot after the last-served requester, wrapping.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!found && req[(int'(rr_q) + k) % NREQ]) begin
                found = 1'b1;
                pick  = GW'((int'(rr_q) + k) % NREQ);
            end
        end
    end

    assign pick_src = src_sel[pick*SELW +: SELW];
    assign pick_dst = dst_sel[pick*SELW +: SELW];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        g_d     = g_q;
        src_d   = src_q;
        dst_d   = dst_q;
        ba_d    = ba_q;
        gnt_d   = gnt_q;
        done_d  = done_q;
        rout_d  = rout_q;
        rin_d   = rin_q;
        baout_d = baout_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d     = S_DRIVE;
                    g_d         = pick;
                    src_d       = pick_src;
                    dst_d       = pick_dst;
                    ba_d        = ba_mode[pick];
                    gnt_d       = '0;
                    gnt_d[pick] = 1'b1;
                    rout_d      = dec(pick_src);
                    baout_d     = ba_mode[pick] && (pick_src == '0);
                    busy_d      = 1'b1;
                end
            end
            S_DRIVE: begin
                state_d = S_WRITE;
                rin_d   = dec(dst_q);
            end
            S_WRITE: begin
                state_d     = S_DONE;
                rout_d      = '0;
                rin_d       = '0;
                baout_d     = 1'b0;
                done_d      = '0;
                done_d[g_q] = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
                done_d  = '0;
                busy_d  = 1'b0;
                rr_d    = g_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= S_IDLE;
            rr_q    <= GW'(NREQ - 1);
            g_q     <= '0;
            src_q   <= '0;
            dst_q   <= '0;
            ba_q    <= 1'b0;
            gnt_q   <= '0;
            done_q  <= '0;
            rout_q  <= '0;
            rin_q   <= '0;
            baout_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            g_q     <= g_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            ba_q    <= ba_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            rout_q  <= rout_d;
            rin_q   <= rin_d;
            baout_q <= baout_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt   = gnt_q;
    assign done  = done_q;
    assign rout  = rout_q;
    assign rin   = rin_q;
    assign baout = baout_q;
    assign busy  = busy_q;
endmodule

// File: tb/tb_reg_xfer_arbiter.sv
// Scoreboard bench for reg_xfer_arbiter: a transfer-level model predicts every
// cycle's outputs into a queue; a negedge monitor pops and compares.
module tb_reg_xfer_arbiter;
    localparam int NREQ = 4;
    localparam int NREG = 16;
    localparam int SELW = 4;

    logic                 clk = 1'b0;
    logic                 clr = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ*SELW-1:0] src_sel = '0;
    logic [NREQ*SELW-1:0] dst_sel = '0;
    logic [NREQ-1:0]      ba_mode = '0;
    logic [NREQ-1:0]      gnt, done;
    logic [NREG-1:0]      rout, rin;
    logic                 baout, busy;

    reg_xfer_arbiter #(.NREQ(NREQ), .NREG(NREG), .SELW(SELW)) dut (
        .clk(clk), .clr(clr), .req(req), .src_sel(src_sel), .dst_sel(dst_sel),
        .ba_mode(ba_mode), .gnt(gnt), .done(done), .rout(rout), .rin(rin),
        .baout(baout), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NREQ-1:0] gnt;
        logic [NREQ-1:0] done;
        logic [NREG-1:0] rout;
        logic [NREG-1:0] rin;
        logic            baout;
        logic            busy;
    } obs_t;

    obs_t expq[$];
    int   vectors = 0;
    int   miscompares = 0;

    // Model: phase counts cycles since the grant (0 = idle), last = last served.
    int ph = 0, mg = 0, msrc = 0, mdst = 0, last = NREQ - 1;
    bit mba = 1'b0;

    function automatic logic [NREG-1:0] onehot_reg(input int idx);
        logic [NREG-1:0] v;
        v = '0;
        if (idx < NREG) v[idx] = 1'b1;
        return v;
    endfunction

    function automatic obs_t model_out();
        obs_t e;
        e = '0;
        if (ph != 0) begin
            e.gnt      = '0;
            e.gnt[mg]  = 1'b1;
            e.busy     = 1'b1;
        end
        if (ph == 1 || ph == 2) begin
            e.rout  = onehot_reg(msrc);
            e.baout = mba && (msrc == 0);
        end
        if (ph == 2) e.rin = onehot_reg(mdst);
        if (ph == 3) e.done[mg] = 1'b1;
        return e;
    endfunction

    function automatic logic [NREQ*SELW-1:0] fld(input int i, input int v);
        logic [NREQ*SELW-1:0] x;
        x = '0;
        x[i*SELW +: SELW] = SELW'(v);
        return x;
    endfunction

    // Drive inputs for the next edge and push the outputs expected after it.
    task automatic step(input logic [NREQ-1:0] r, input logic [NREQ*SELW-1:0] s,
                        input logic [NREQ*SELW-1:0] d, input logic [NREQ-1:0] b,
                        input logic c);
        @(negedge clk);
        #1;
        req = r; src_sel = s; dst_sel = d; ba_mode = b; clr = c;
        if (!c) begin
            ph = 0;
            last = NREQ - 1;
        end else if (ph == 0) begin
            if (r != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    if (ph == 0 && r[(last + k) % NREQ]) begin
                        mg   = (last + k) % NREQ;
                        msrc = int'((s >> (mg * SELW)) & {{(NREQ*SELW-SELW){1'b0}}, {SELW{1'b1}}});
                        mdst = int'((d >> (mg * SELW)) & {{(NREQ*SELW-SELW){1'b0}}, {SELW{1'b1}}});
                        mba  = b[mg];
                        ph   = 1;
                    end
                end
            end
        end else if (ph == 3) begin
            last = mg;
            ph   = 0;
        end else begin
            ph = ph + 1;
        end
        expq.push_back(model_out());
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, src_sel, dst_sel, ba_mode, 1'b1);
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {gnt, done, rout, rin, baout, busy};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL cycle t=%0t got gnt=%b done=%b rout=%h rin=%h baout=%b busy=%b want gnt=%b done=%b rout=%h rin=%h baout=%b busy=%b",
                         $time, a.gnt, a.done, a.rout, a.rin, a.baout, a.busy,
                         e.gnt, e.done, e.rout, e.rin, e.baout, e.busy);
            end
        end
    end

    initial begin
        // Reset state
        for (int i = 0; i < 3; i++) step('0, '0, '0, '0, 1'b0);
        idle(1);

        // Single move 3 -> 7
        step(4'b0001, fld(0, 3), fld(0, 7), 4'b0000, 1'b1);
        idle(5);

        // Base-address override, then the same move without it
        step(4'b0010, fld(1, 0), fld(1, 5), 4'b0010, 1'b1);
        idle(5);
        step(4'b0010, fld(1, 0), fld(1, 5), 4'b0000, 1'b1);
        idle(5);

        // All requesters held: rotating grants every 4 cycles
        for (int i = 0; i < 22; i++)
            step(4'b1111, 16'($urandom), 16'($urandom), 4'($urandom), 1'b1);
        idle(4);

        // Priority after service
        step(4'b0100, 16'h0a00, 16'h0b00, 4'b0000, 1'b1);
        idle(4);
        step(4'b0101, 16'h0302, 16'h0504, 4'b0000, 1'b1);
        idle(4);
        step(4'b0110, 16'h0760, 16'h0980, 4'b0000, 1'b1);
        idle(5);

        // Request drop and field change after grant
        step(4'b0001, fld(0, 2), fld(0, 9), 4'b0000, 1'b1);
        step(4'b0000, fld(0, 12), fld(0, 1), 4'b0001, 1'b1);
        step(4'b0000, fld(0, 0), fld(0, 4), 4'b0001, 1'b1);
        idle(3);

        // Reset in the WRITE cycle: strobes must drop immediately
        step(4'b0001, fld(0, 6), fld(0, 8), 4'b0000, 1'b1);
        step(4'b0000, fld(0, 6), fld(0, 8), 4'b0000, 1'b1);
        step(4'b0000, fld(0, 6), fld(0, 8), 4'b0000, 1'b0);
        #1;
        vectors++;
        if ({gnt, done, rout, rin, busy} !== '0) begin
            miscompares++;
            $display("FAIL async-clear got gnt=%b done=%b rout=%h rin=%h busy=%b want all zero",
                     gnt, done, rout, rin, busy);
        end
        step(4'b1000, fld(3, 1), fld(3, 2), 4'b0000, 1'b1);
        idle(5);

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++)
            step(4'($urandom), 16'($urandom), 16'($urandom), 4'($urandom),
                 ($urandom_range(0, 63) != 0));
        idle(6);

        @(negedge clk);
        #2;
        vectors++;
        if (expq.size() != 0) begin
            miscompares++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/reg_xfer_arbiter.md
Name: reg_xfer_arbiter

Overview:
- Sequences register-to-register moves over the shared 32-bit datapath bus for up to NREQ requesters.
- Round-robin arbitration picks one requester at a time. The block then drives the one-hot register out-enables (rout), the in-enables (rin) and the base-address zero override (baout) for the 32-bit registers.
- Sits between requesting control blocks and the register file; it is the only source of register rout/rin/baout strobes.

Parameters:
- NREQ, 4, number of requesters.
- NREG, 16, number of 32-bit registers on the bus.
- SELW, 4, register index width; must satisfy 2**SELW >= NREG.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  reset; asynchronous, active-low.
- req  in  NREQ  per-requester transfer request, level; held until the matching gnt bit rises.
- src_sel  in  NREQ*SELW  source register index; requester i uses bits [i*SELW +: SELW].
- dst_sel  in  NREQ*SELW  destination register index, same packing as src_sel.
- ba_mode  in  NREQ  base-address mode: a source index of 0 reads as zero.
- gnt  out  NREQ  one-hot grant; held for the whole transfer.
- done  out  NREQ  one-hot, 1-cycle pulse in the final transfer cycle.
- rout  out  NREG  one-hot register out-enable onto the bus.
- rin  out  NREG  one-hot register write enable.
- baout  out  1  forces the R0 output to zero.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- All outputs are registered.
- Reset (clr=0, asynchronous): state=IDLE; gnt, done, rout, rin, baout, busy=0; rr_ptr=NREQ-1, so requester 0 has highest priority first.
- States: IDLE -> DRIVE -> WRITE -> DONE -> IDLE, one cycle each except IDLE.
- IDLE:
  - If any req bit is high at the clock edge, select the first set bit searching upward from (rr_ptr+1) mod NREQ, wrapping around.
  - Latch that requester's index g, src, dst and ba into internal registers; go to DRIVE.
  - If no req bit is high, stay in IDLE.
- DRIVE:
  - gnt[g]=1, busy=1, rout[src]=1.
  - baout=1 iff ba latched high and src==0; otherwise baout=0.
  - rin=0. This is the bus settling cycle.
- WRITE: gnt, rout and baout unchanged; rin[dst]=1. The register captures the bus at the end of this cycle.
- DONE:
  - done[g]=1, gnt[g] still 1; rout, rin and baout=0.
  - rr_ptr<=g. Next state is IDLE, where gnt, done and busy return to 0.
- Latency and throughput:
  - Request sampled at edge k gives gnt high in cycles k+1..k+3, rin in cycle k+2, done in cycle k+3.
  - Maximum throughput is one transfer per 4 cycles.
- Round-robin: the last-served requester has lowest priority at the next arbitration; a requester cannot starve while others hold req continuously.
- Request and field sampling:
  - src_sel, dst_sel and ba_mode are sampled only at the arbitration edge; later changes have no effect.
  - req dropping after grant does not abort the transfer; done still pulses.
  - req still high in the IDLE cycle after done is treated as a new request.
- src==dst is legal: the register is rewritten with its own value, or with 0 when the baout override applies.
- dst==0 is legal.
- Index >= NREG: the transfer sequences normally with rout/rin all zero for the out-of-range side. No other error action is taken.
- At most one bit of rout, rin, gnt or done is ever high. rin and rout never select a register that was not latched.
- Reset mid-transfer clears all strobes immediately, with no done pulse. The interrupted transfer is lost.

Test Plan:
- Single move: req=4'b0001, src0=3, dst0=7, ba0=0 at edge 0 -> rout=16'h0008 in cycles 1-2; rin=16'h0080 only in cycle 2; done=4'b0001 in cycle 3; busy low in cycle 4.
- BA override: req1 with src=0, dst=5, ba=1 -> rout=16'h0001 and baout=1 in cycles 1-2; rin=16'h0020 in cycle 2. Same move with ba=0 -> baout stays 0.
- Round-robin fairness: req=4'b1111 held continuously -> grant order 0,1,2,3,0 with consecutive grants 4 cycles apart.
- Priority after service: serve requester 2, then assert req=4'b0101 -> requester 0 is granted. Then req=4'b0110 -> requester 1 is granted first.
- Request drop and field change: after the grant, drop req and change src_sel -> the original src remains on rout and done still pulses in cycle 3.
- Reset mid-transfer: clr=0 during WRITE -> rin, rout, gnt and busy fall within the same cycle with no done pulse. After release, req=4'b1000 with rr_ptr at its reset value -> requester 3 is granted normally.
